ifu_isram_axil: RTL



---
 rtl/ysyx_23060251_axi_pkg.sv | 28 ++
 rtl/ifu_isram_lfsr.sv | 24 ++
 rtl/ifu_isram_axil.sv | 112 +++++++++++
 3 files changed

// File: rtl/ysyx_23060251_axi_pkg.sv
// Shared AXI-Lite definitions for the fetch-side instruction SRAM slave.
// Holds the response codes, the slave FSM state encoding, the LFSR feedback
// taps and the instruction memory image read by the slave.
package ysyx_23060251_axi_pkg;

  localparam logic [1:0] AXI_OKAY   = 2'b00;
  localparam logic [1:0] AXI_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_SLVERR = 2'b10;
  localparam logic [1:0] AXI_DECERR = 2'b11;

  // x^8+x^6+x^5+x^4+1 in right-shifting Galois form
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'b001,
    S_DELAY = 3'b010,
    S_RESP  = 3'b100
  } state_e;

  // Instruction memory image: a short boot sequence at the window base,
  // an address-derived pattern everywhere else.
  function automatic int pmem_read(input int addr);
    if (addr == 32'h8000_0000) return 32'h0000_0413;
    if (addr == 32'h8000_0004) return 32'h0000_0493;
    return addr ^ 32'h1357_9BDF;
  endfunction

endpackage

// File: rtl/ifu_isram_lfsr.sv
// 8-bit Galois LFSR used to draw per-request bus latency.
// Ports: clk_i/rst_i (async, active-low), en_i advance enable,
//        val_o current LFSR state.
module ifu_isram_lfsr
  import ysyx_23060251_axi_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  output logic [7:0] val_o
);

  logic [7:0] r_lfsr;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)    r_lfsr <= SEED;
    else if (en_i) r_lfsr <= {1'b0, r_lfsr[7:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 8'h00);
  end

  assign val_o = r_lfsr;

endmodule

// File: rtl/ifu_isram_axil.sv
// Read-only AXI-Lite instruction SRAM slave in front of the fetch unit.
// One outstanding read: AR accepted in IDLE, optional DELAY countdown,
// response held in RESP until the R handshake.
// Ports: clk_i/rst_i (async, active-low); slv_ar_* read address channel;
//        slv_r_* read data channel; req_cnt_o completed R handshakes.
module ifu_isram_axil
  import ysyx_23060251_axi_pkg::*;
#(
  parameter int unsigned         ADDR_W     = 32,
  parameter int unsigned         DATA_W     = 32,
  parameter logic [ADDR_W-1:0]   BASE_ADDR  = 32'h8000_0000,
  parameter logic [ADDR_W-1:0]   MEM_BYTES  = 32'h0800_0000,
  parameter int unsigned         FIXED_LAT  = 1,
  parameter bit                  RANDOM_LAT = 1'b0,
  parameter logic [7:0]          LAT_MASK   = 8'h07,
  parameter logic [7:0]          LFSR_SEED  = 8'hA5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              slv_ar_valid_i,
  input  logic [ADDR_W-1:0] slv_ar_addr_i,
  output logic              slv_ar_ready_o,
  output logic              slv_r_valid_o,
  output logic [DATA_W-1:0] slv_r_data_o,
  output logic [1:0]        slv_r_resp_o,
  input  logic              slv_r_ready_i,
  output logic [31:0]       req_cnt_o
);

  // one extra bit so BASE_ADDR+MEM_BYTES cannot wrap
  localparam logic [ADDR_W:0] LP_LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0] LP_HI = LP_LO + {1'b0, MEM_BYTES};

  state_e              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_addr, w_cap_addr;
  logic [7:0]          r_cnt, w_lfsr, w_lat;
  logic [DATA_W-1:0]   r_data, w_data;
  logic [1:0]          r_resp, w_resp;
  logic [31:0]         r_req_cnt;
  logic                w_ar_hs, w_r_hs, w_capture;

  ifu_isram_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (1'b1),
    .val_o (w_lfsr)
  );

  assign w_ar_hs   = slv_ar_valid_i & (r_state == S_IDLE);
  assign w_r_hs    = slv_r_ready_i & (r_state == S_RESP);
  assign w_lat     = RANDOM_LAT ? (w_lfsr & LAT_MASK) : 8'(FIXED_LAT);
  // zero latency captures straight from the bus on the AR edge
  assign w_capture = (w_ar_hs && w_lat == 8'd0) || (r_state == S_DELAY && r_cnt == 8'd0);
  assign w_cap_addr = (r_state == S_IDLE) ? slv_ar_addr_i : r_addr;

  always_comb begin
    w_data = '0;
    w_resp = AXI_DECERR;
    if ({1'b0, w_cap_addr} >= LP_LO && {1'b0, w_cap_addr} < LP_HI) begin
      if (w_cap_addr[1:0] != 2'b00) begin
        w_resp = AXI_SLVERR;
      end else begin
        w_resp = AXI_OKAY;
        w_data = DATA_W'(pmem_read(int'(w_cap_addr)));
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_ar_hs) w_state_nxt = (w_lat == 8'd0) ? S_RESP : S_DELAY;
      S_DELAY: if (r_cnt == 8'd0) w_state_nxt = S_RESP;
      S_RESP:  if (w_r_hs) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_addr    <= '0;
      r_cnt     <= '0;
      r_data    <= '0;
      r_resp    <= AXI_OKAY;
      r_req_cnt <= '0;
    end else begin
      if (w_ar_hs) begin
        r_addr <= slv_ar_addr_i;
        r_cnt  <= w_lat - 8'd1;
      end else if (r_state == S_DELAY && r_cnt != 8'd0) begin
        r_cnt <= r_cnt - 8'd1;
      end
      if (w_capture) begin
        r_data <= w_data;
        r_resp <= w_resp;
      end
      if (w_r_hs) r_req_cnt <= r_req_cnt + 32'd1;
    end
  end

  assign slv_ar_ready_o = (r_state == S_IDLE);
  assign slv_r_valid_o  = (r_state == S_RESP);
  assign slv_r_data_o   = r_data;
  assign slv_r_resp_o   = r_resp;
  assign req_cnt_o      = r_req_cnt;

endmodule
